motoro_301_top: RTL and testbench

//  Top level of the 3-phase motor demo board on a 50 MHz clock.
//  - Free-running 6-step commutation sequencer.
//  - PWM and step-strobe outputs on test points tp01/tp02.
//  - Step pattern plus heartbeat shown on led4.
//  - Reports each new step as one ASCII byte on an RS-232 8N1 transmitter.

---
 rtl/motoro301_pkg.sv | 16 +
 rtl/motoro301_uart_tx.sv | 78 +++++++
 rtl/motoro_301_top.sv | 96 +++++++++
 tb/tb_motoro_301_top.sv | 136 +++++++++++++
 4 files changed

// File: rtl/motoro301_pkg.sv
// Shared constants and types for the 3-phase motor demo board.
package motoro301_pkg;

  localparam logic [7:0] ASCII_0 = 8'h30;

  // One-hot-ish phase pattern driven onto led4[3:1], indexed by step
  localparam logic [2:0] STEP_PAT [0:5] = '{3'b001, 3'b011, 3'b010,
                                            3'b110, 3'b100, 3'b101};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  function automatic logic [2:0] next_step(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

endpackage

// File: rtl/motoro301_uart_tx.sv
// 8N1 UART transmitter, LSB first, idle high, registered output.
module motoro301_uart_tx
  import motoro301_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  uart_state_e   r_state, w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shreg;
  logic          r_tx, w_tx_nxt;
  logic          w_baud_done;

  assign w_baud_done = (r_baud == BW'(BAUD_DIV - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = 1'b1;
    case (r_state)
      IDLE:  if (send) w_state_nxt = START;
      START: if (w_baud_done) begin
               w_state_nxt = DATA;
               w_bit_nxt   = 3'd0;
             end
      DATA:  if (w_baud_done) begin
               if (r_bit == 3'd7) w_state_nxt = STOP;
               else               w_bit_nxt   = r_bit + 3'd1;
             end
      STOP:  if (w_baud_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Line level is computed from the next state so tx is a clean flop output
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = r_shreg[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud  <= '0;
      r_shreg <= 8'h00;
    end else if (r_state == IDLE) begin
      r_baud <= '0;
      if (send) r_shreg <= data;
    end else begin
      r_baud <= w_baud_done ? '0 : r_baud + BW'(1);
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != IDLE);

endmodule

// File: rtl/motoro_301_top.sv
// Motor demo top: 6-step commutation, PWM, heartbeat LED and step report over UART.
module motoro_301_top
  import motoro301_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned STEP_DIV   = 500_000,
  parameter int unsigned HB_DIV     = 25_000_000,
  parameter int unsigned PWM_PERIOD = 1000,
  parameter int unsigned PWM_DUTY   = 250
) (
  input  logic       clk50mhz,
  input  logic       nReset,
  output logic       tp01,
  output logic       tp02,
  output logic       rs232_tx,
  output logic [3:0] led4
);

  localparam int SW = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
  localparam int HW = (HB_DIV     > 1) ? $clog2(HB_DIV)     : 1;
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  logic [SW-1:0] r_step_cnt;
  logic [HW-1:0] r_hb_cnt;
  logic [PW-1:0] r_pwm_cnt;
  logic [2:0]    r_step;
  logic [2:0]    r_led_pat;
  logic          r_step_evt;
  logic          r_tp01, r_tp02, r_hb;
  logic          w_uart_busy;
  logic          w_uart_tx;

  // Step advance, tp02 toggle and the UART event all land on the same edge
  always_ff @(posedge clk50mhz) begin
    if (nReset) begin
      r_step_cnt <= '0;
      r_step     <= 3'd0;
      r_tp02     <= 1'b0;
      r_step_evt <= 1'b0;
    end else begin
      r_step_evt <= 1'b0;
      if (r_step_cnt == SW'(STEP_DIV - 1)) begin
        r_step_cnt <= '0;
        r_step     <= next_step(r_step);
        r_tp02     <= ~r_tp02;
        r_step_evt <= 1'b1;
      end else begin
        r_step_cnt <= r_step_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (nReset) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (r_hb_cnt == HW'(HB_DIV - 1)) begin
      r_hb_cnt <= '0;
      r_hb     <= ~r_hb;
    end else begin
      r_hb_cnt <= r_hb_cnt + HW'(1);
    end
  end

  // Full-width compare keeps duty 0 / duty >= period as constant levels
  always_ff @(posedge clk50mhz) begin
    if (nReset) begin
      r_pwm_cnt <= '0;
      r_tp01    <= 1'b0;
    end else begin
      r_tp01    <= (32'(r_pwm_cnt) < PWM_DUTY);
      r_pwm_cnt <= (r_pwm_cnt == PW'(PWM_PERIOD - 1)) ? '0 : r_pwm_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (nReset) r_led_pat <= STEP_PAT[0];
    else        r_led_pat <= STEP_PAT[r_step];
  end

  motoro301_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk  (clk50mhz),
    .rst  (nReset),
    .send (r_step_evt & ~w_uart_busy),
    .data (ASCII_0 + {5'd0, r_step}),
    .tx   (w_uart_tx),
    .busy (w_uart_busy)
  );

  assign tp01     = r_tp01;
  assign tp02     = r_tp02;
  assign rs232_tx = w_uart_tx;
  assign led4     = {r_led_pat, r_hb};

endmodule

// File: tb/tb_motoro_301_top.sv
// Scoreboard bench: main process drives reset/timeline, monitors decode UART frames.
module tb_motoro_301_top;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       tp01_a, tp02_a, tx_a, tp01_b, tp02_b, tx_b;
  logic [3:0] led_a, led_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic abort_a = 1'b0;

  always #10 clk = ~clk;

  motoro_301_top #(.BAUD_DIV(BD), .STEP_DIV(64), .HB_DIV(16), .PWM_PERIOD(8), .PWM_DUTY(2))
  dut_a (.clk50mhz(clk), .nReset(rst_a), .tp01(tp01_a), .tp02(tp02_a),
         .rs232_tx(tx_a), .led4(led_a));

  motoro_301_top #(.BAUD_DIV(BD), .STEP_DIV(30), .HB_DIV(16), .PWM_PERIOD(8), .PWM_DUTY(2))
  dut_b (.clk50mhz(clk), .nReset(rst_b), .tp01(tp01_b), .tp02(tp02_b),
         .rs232_tx(tx_b), .led4(led_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pat(input int s);
    case (s)
      0: return 3'b001;
      1: return 3'b011;
      2: return 3'b010;
      3: return 3'b110;
      4: return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  // n = number of rising edges since reset release
  task automatic run_a(input int n0, input int n1);
    for (int n = n0; n <= n1; n++) begin
      @(negedge clk);
      chk("tp01", tp01_a, 32'(((n - 1) % 8) < 2));
      chk("tp02", tp02_a, 32'((n / 64) % 2));
      chk("led4", led_a, {28'd0, pat(((n - 1) / 64) % 6), 1'((n / 16) % 2)});
    end
  endtask

  task automatic rx_frame(input bit which, output logic [9:0] f);
    do @(negedge clk); while ((which ? tx_b : tx_a) !== 1'b0);
    repeat (BD / 2) @(negedge clk);
    f[0] = which ? tx_b : tx_a;
    for (int i = 1; i < 10; i++) begin
      repeat (BD) @(negedge clk);
      f[i] = which ? tx_b : tx_a;
    end
  endtask

  initial begin : mon_a
    logic [9:0] f;
    logic [7:0] e;
    forever begin
      rx_frame(1'b0, f);
      if (abort_a) begin
        abort_a = 1'b0;
        if (qa.size() > 0) qa.delete(0);
      end else if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL uart_a unexpected frame actual=%h", f);
      end else begin
        e = qa.pop_front();
        chk("uart_a", 32'(f), 32'({1'b1, e, 1'b0}));
      end
    end
  end

  initial begin : mon_b
    logic [9:0] f;
    logic [7:0] e;
    forever begin
      rx_frame(1'b1, f);
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL uart_b unexpected frame actual=%h", f);
      end else begin
        e = qb.pop_front();
        chk("uart_b", 32'(f), 32'({1'b1, e, 1'b0}));
      end
    end
  end

  initial begin : main
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("reset_a", {25'd0, tx_a, led_a, tp01_a, tp02_a}, 32'b1_0010_0_0);
      chk("reset_b_tx", tx_b, 1);
    end
    foreach (qa[i]) qa.delete(i);
    qa.push_back(8'h31); qa.push_back(8'h32); qa.push_back(8'h33);
    qa.push_back(8'h34); qa.push_back(8'h35); qa.push_back(8'h30);
    // 30-clock steps against a 40-clock frame: every other byte is dropped
    qb.push_back(8'h31); qb.push_back(8'h33); qb.push_back(8'h35);
    qb.push_back(8'h31); qb.push_back(8'h33); qb.push_back(8'h35);
    qb.push_back(8'h31);
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      begin repeat (445) @(negedge clk); rst_b = 1'b1; end
    join_none
    run_a(1, 430);
    chk("qa_drain_six_steps", qa.size(), 0);
    qa.push_back(8'h31);
    run_a(431, 460);
    abort_a = 1'b1;
    rst_a   = 1'b1;
    @(negedge clk);
    chk("reset_pulse", {25'd0, tx_a, led_a, tp01_a, tp02_a}, 32'b1_0010_0_0);
    rst_a = 1'b0;
    qa.push_back(8'h31);
    run_a(1, 114);
    chk("qa_drain_after_reset", qa.size(), 0);
    chk("qb_drain_dropped", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
